// File: rtl/controlador_sincronia.sv
// controlador_sincronia: frame alignment hunt, confirm and lock controller.
// Emits each locked word and counts lock losses.
module controlador_sincronia #(
    parameter int             N            = 5,
    parameter logic [N-1:0]   SECUENCIA    = 5'b10100,
    parameter logic [N-1:0]   SEC_REINICIO = 5'b00000,
    parameter int             M_SINC       = 1,
    parameter int             M_PERD       = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_in,
    output logic         valido,
    output logic         nuevo_numero,
    output logic [N-1:0] dato,
    output logic [1:0]   estado,
    output logic [7:0]   perdidas
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] ULT = CW'(N - 1);
    localparam logic [3:0] MS = 4'(M_SINC);
    localparam logic [3:0] MP = 4'(M_PERD);

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        PRESYNC = 2'b01,
        LOCK    = 2'b10,
        ILEGAL  = 2'b11
    } estado_t;

    estado_t       st;
    logic [N-2:0]  sr;
    logic [N-1:0]  w;
    logic [CW-1:0] cnt;
    logic [3:0]    good;
    logic [3:0]    bad;
    logic          fin;

    // Window holds the N newest bits, including the one sampled now
    assign w      = {sr, s_in};
    assign fin    = (cnt == ULT);
    assign estado = st;

    // Sync state machine with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st           <= HUNT;
            sr           <= '0;
            cnt          <= '0;
            good         <= '0;
            bad          <= '0;
            dato         <= '0;
            perdidas     <= '0;
            valido       <= 1'b0;
            nuevo_numero <= 1'b0;
        end else begin
            sr           <= w[N-2:0];
            nuevo_numero <= 1'b0;
            cnt          <= fin ? '0 : cnt + 1'b1;
            case (st)
                HUNT: begin
                    if (w == SECUENCIA) begin
                        good <= 4'd1;
                        cnt  <= '0;
                        if (M_SINC == 1) begin
                            st     <= LOCK;
                            valido <= 1'b1;
                            bad    <= '0;
                        end else begin
                            st <= PRESYNC;
                        end
                    end
                end
                PRESYNC: begin
                    if (fin) begin
                        if (w == SECUENCIA) begin
                            good <= good + 4'd1;
                            if (good + 4'd1 == MS) begin
                                st     <= LOCK;
                                cnt    <= '0;
                                bad    <= '0;
                                valido <= 1'b1;
                            end
                        end else begin
                            st   <= HUNT;
                            good <= '0;
                        end
                    end
                end
                LOCK: begin
                    if (fin) begin
                        if (w == SEC_REINICIO) begin
                            if (bad + 4'd1 == MP) begin
                                st     <= HUNT;
                                valido <= 1'b0;
                                bad    <= '0;
                                good   <= '0;
                                if (perdidas != 8'hFF)
                                    perdidas <= perdidas + 8'd1;
                            end else begin
                                bad <= bad + 4'd1;
                            end
                        end else begin
                            bad          <= '0;
                            dato         <= w;
                            nuevo_numero <= 1'b1;
                        end
                    end
                end
                default: begin
                    st     <= HUNT;
                    valido <= 1'b0;
                    good   <= '0;
                    bad    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_sincronia.sv
// tb_controlador_sincronia: directed checks of hunt, lock, loss,
// multi-frame confirm/loss, async reset and loss-counter saturation.
module tb_controlador_sincronia;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;

    logic       val0, val1, val2;
    logic       nv0, nv1, nv2;
    logic [4:0] dat0, dat1, dat2;
    logic [1:0] est0, est1, est2;
    logic [7:0] per0, per1, per2;

    int checks = 0;
    int errors = 0;
    int strb [3];
    logic sawval [3];

    always #5 clk = ~clk;

    controlador_sincronia dut0 (
        .clk(clk), .rst(rst), .s_in(s0), .valido(val0),
        .nuevo_numero(nv0), .dato(dat0), .estado(est0), .perdidas(per0)
    );

    controlador_sincronia #(.M_SINC(2)) dut1 (
        .clk(clk), .rst(rst), .s_in(s1), .valido(val1),
        .nuevo_numero(nv1), .dato(dat1), .estado(est1), .perdidas(per1)
    );

    controlador_sincronia #(.M_PERD(2)) dut2 (
        .clk(clk), .rst(rst), .s_in(s2), .valido(val2),
        .nuevo_numero(nv2), .dato(dat2), .estado(est2), .perdidas(per2)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit1(input int d, input logic b);
        @(negedge clk);
        case (d)
            0: s0 = b;
            1: s1 = b;
            default: s2 = b;
        endcase
        @(posedge clk);
        #1;
        case (d)
            0: begin strb[0] += int'(nv0); sawval[0] |= val0; end
            1: begin strb[1] += int'(nv1); sawval[1] |= val1; end
            default: begin strb[2] += int'(nv2); sawval[2] |= val2; end
        endcase
    endtask

    task automatic word(input int d, input logic [4:0] wv);
        for (int i = 4; i >= 0; i--) bit1(d, wv[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strb[i] = 0;
            sawval[i] = 1'b0;
        end
    endtask

    initial begin
        do_reset();
        check("rst_estado", 32'(est0), 32'd0);
        check("rst_valido", 32'(val0), 32'd0);
        check("rst_nuevo", 32'(nv0), 32'd0);
        check("rst_dato", 32'(dat0), 32'd0);
        check("rst_perdidas", 32'(per0), 32'd0);

        word(0, 5'b11011);
        check("a_hunt_estado", 32'(est0), 32'd0);
        check("a_hunt_valido", 32'(sawval[0]), 32'd0);
        check("a_hunt_strobe", 32'(strb[0]), 32'd0);

        word(0, 5'b10100);
        check("a_lock_estado", 32'(est0), 32'd2);
        check("a_lock_valido", 32'(val0), 32'd1);
        check("a_lock_strobe", 32'(strb[0]), 32'd0);

        word(0, 5'b11001);
        check("a_word_nuevo", 32'(nv0), 32'd1);
        check("a_word_dato", 32'(dat0), 32'h19);
        check("a_word_strobes", 32'(strb[0]), 32'd1);
        bit1(0, 1'b0);
        check("a_word_pulse1", 32'(nv0), 32'd0);

        for (int i = 0; i < 4; i++) bit1(0, 1'b0);
        check("a_loss_valido", 32'(val0), 32'd0);
        check("a_loss_estado", 32'(est0), 32'd0);
        check("a_loss_perdidas", 32'(per0), 32'd1);
        check("a_loss_strobes", 32'(strb[0]), 32'd1);
        check("a_loss_dato", 32'(dat0), 32'h19);

        word(0, 5'b10100);
        check("d_relock_estado", 32'(est0), 32'd2);
        bit1(0, 1'b1);
        bit1(0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("d_async_valido", 32'(val0), 32'd0);
        check("d_async_estado", 32'(est0), 32'd0);
        check("d_async_perdidas", 32'(per0), 32'd0);
        check("d_async_dato", 32'(dat0), 32'd0);

        do_reset();
        word(1, 5'b10100);
        check("b_presync", 32'(est1), 32'd1);
        word(1, 5'b10101);
        check("b_back_hunt", 32'(est1), 32'd0);
        check("b_never_valido", 32'(sawval[1]), 32'd0);

        do_reset();
        word(1, 5'b10100);
        check("b2_presync", 32'(est1), 32'd1);
        for (int i = 4; i >= 1; i--) bit1(1, i[2] ? 1'b1 : (i == 2));
        check("b2_bit9_estado", 32'(est1), 32'd1);
        bit1(1, 1'b0);
        check("b2_bit10_estado", 32'(est1), 32'd2);
        check("b2_bit10_valido", 32'(val1), 32'd1);

        do_reset();
        word(2, 5'b10100);
        check("c_lock", 32'(est2), 32'd2);
        word(2, 5'b00000);
        check("c_hold1", 32'(est2), 32'd2);
        word(2, 5'b01111);
        check("c_dato", 32'(dat2), 32'h0F);
        word(2, 5'b00000);
        check("c_hold2_estado", 32'(est2), 32'd2);
        check("c_hold2_valido", 32'(val2), 32'd1);
        check("c_strobes", 32'(strb[2]), 32'd1);
        check("c_perdidas", 32'(per2), 32'd0);

        do_reset();
        for (int k = 0; k < 260; k++) begin
            word(0, 5'b10100);
            word(0, 5'b00000);
            if (k == 253) check("e_per254", 32'(per0), 32'd254);
        end
        check("e_saturated", 32'(per0), 32'd255);
        check("e_valido", 32'(val0), 32'd0);
        check("e_strobes", 32'(strb[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_sincronia.md
Name: controlador_sincronia

Overview:
Frame-synchronisation controller for the serial code-detection path. It hunts bit-by-bit for the alignment word SECUENCIA on s_in, then confirms alignment on frame boundaries and locks. While locked, it delivers each N-bit word and drops lock when loss words (SEC_REINICIO) are received. It sequences the detector by owning the bit counter, lock state and frame strobes that downstream logic consumes.

Parameters:
N, 5, frame/word width in bits (2..16)
SECUENCIA, 5'b10100, alignment word (N bits)
SEC_REINICIO, 5'b00000, loss-of-sync word (N bits)
M_SINC, 1, consecutive aligned SECUENCIA frames required to lock (1..15)
M_PERD, 1, consecutive SEC_REINICIO frames required to drop lock (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
s_in  input  1  serial data, MSB of each frame first
valido  output  1  high while in the LOCK state
nuevo_numero  output  1  one-cycle strobe: dato holds a new word
dato  output  N  last delivered word
estado  output  2  00 HUNT, 01 PRESYNC, 10 LOCK
perdidas  output  8  count of lock losses, saturating

Behaviour:
- Reset (rst=0, asynchronous): state HUNT; shift register, bit counter, good/bad counters, dato and perdidas all cleared; valido=0; nuevo_numero=0. Outputs change immediately, without a clock edge, including mid-frame in LOCK.
- Shift register: sr <= {sr[N-2:0], s_in} on every edge, in every state.
- Window: w = {sr[N-2:0], s_in}, i.e. the N most recent bits including the one sampled at this edge. All decisions use w and are registered at the same edge. Outputs therefore reflect a decision one cycle after the last bit is driven.
- Bit counter cnt (0..N-1): cleared when entering PRESYNC or LOCK; increments each edge. A frame boundary occurs at an edge where cnt==N-1; cnt then wraps to 0.
- HUNT: w is checked every edge. If w==SECUENCIA: good=1, cnt=0, and the next state is LOCK if M_SINC==1, otherwise PRESYNC. If there is no match, the state stays HUNT.
- PRESYNC: action only at frame boundaries.
  - w==SECUENCIA: good++. If good reaches M_SINC, go to LOCK with cnt=0 and bad=0.
  - Any other w: go to HUNT and clear good.
- LOCK: valido=1. Action only at frame boundaries.
  - w==SEC_REINICIO: bad++ and no strobe. If bad reaches M_PERD: go to HUNT, set valido=0 from the next cycle, increment perdidas (saturates at 255), clear bad.
  - Any other w (including SECUENCIA): bad=0, dato<=w, nuevo_numero=1 for exactly one cycle.
- nuevo_numero is never asserted outside LOCK. dato holds its value between strobes and across loss of lock.
- estado is the registered state encoding. Value 11 is unreachable; if ever entered, the next edge forces HUNT.

Test Plan:
- Defaults, rst released, s_in bits 1,1,0,1,1 -> estado=00, valido=0, no nuevo_numero strobe.
- Continue with 1,0,1,0,0 -> at the edge sampling the final 0, estado=10; valido=1 in the following cycle.
- Continue with 1,1,0,0,1 -> exactly one nuevo_numero pulse, dato=5'b11001, one cycle after the last bit.
- Continue with 0,0,0,0,0 -> valido=0 and estado=00 after the last bit; perdidas=1; no strobe; dato stays 5'b11001.
- M_SINC=2: send 10100 then 10101 -> estado goes 00 to 01 to 00 and valido is never 1. Repeat with 10100,10100 -> LOCK at the 10th bit.
- M_PERD=2: in LOCK send 00000, 01111, 00000 -> lock is held, one strobe with dato=5'b01111.
- Reset mid-lock: drive rst=0 between clock edges -> valido, estado and perdidas read 0 before the next edge.
- Saturation: 260 lock/loss cycles -> perdidas=255.
